rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Shares one downstream resource among N_REQ requesters using a rotating-priority (round-robin) scheme.
- Selection is MSB-first within a window that rotates each grant, matching the team's priority-encoder convention (highest index wins at reset).
- Issues a registered one-hot grant plus an encoded index, and holds the grant until the owner releases it.
- Sits in front of shared datapath resources such as bus masters and shared functional units.

Parameters:
- N_REQ, 4, number of requesters; legal range is N_REQ >= 2, and non-power-of-two values are allowed.
- IDX_W, $clog2(N_REQ), localparam, width of grant_idx.
- MAX_HOLD, 16, maximum number of grant cycles before a forced release; used only with ARB_TIMEOUT_EN; legal range is MAX_HOLD >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; must be held until granted.
- done  in  1  owner release strobe; sampled only while grant_valid=1.
- grant  out  N_REQ  one-hot grant; all zeros when idle.
- grant_valid  out  1  a grant is active.
- grant_idx  out  IDX_W  index of the granted requester; 0 when idle.
- timeout  out  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- One clock domain, with reset asynchronous and active-low. All outputs are registered.
- Reset values: grant=0, grant_valid=0, grant_idx=0, timeout=0, state=IDLE, last_ptr=0, hold counter=0.
- Internal pointer last_ptr (IDX_W bits) holds the index of the most recent grant.
- Search order from last_ptr=k is k-1, k-2, ..., 0, N_REQ-1, ..., k, descending with wrap.
  - After reset, k=0, so the order is N_REQ-1 down to 0.
  - Wrap is modulo N_REQ, not 2^IDX_W; indices >= N_REQ never appear.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If |req, register the winner: grant=onehot(w), grant_idx=w, grant_valid=1, last_ptr=w, go to GRANT.
  - Latency from req sampled to grant visible is 1 cycle.
  - If req=0, stay in IDLE with outputs 0.
- GRANT:
  - Release condition is done=1 OR req[grant_idx]=0.
  - On release: next cycle grant=0, grant_valid=0, grant_idx=0, state=IDLE.
  - This gives one mandatory idle bubble between consecutive grants.
  - Without release, hold all outputs; changes on other req bits are ignored.
- Simultaneous done and request drop count as a single release.
- done asserted in IDLE is ignored.
- A winner is only ever a requester whose req bit was 1 in the arbitration cycle.
- Exactly one grant bit is set whenever grant_valid=1.
- Fairness: under continuous requests from all N_REQ requesters, each is granted exactly once in any N_REQ consecutive grants.
- Reset asserted mid-grant clears outputs immediately and asynchronously. last_ptr returns to 0, so the next arbitration restarts from the N_REQ-1 order.
- Arbitration logic is combinational on the rotated request vector: rotate, MSB-first pick, un-rotate. No multi-cycle search.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When MAX_HOLD grant cycles elapse without release, force the release path.
  - timeout=1 for exactly the cycle in which grant_valid first reads 0.
  - A normal release on the same cycle as expiry takes priority: timeout stays 0.
- Undefined: no counter is built, timeout is tied to 0, and a grant can be held indefinitely.

Test Plan:
- Reset, N_REQ=4, req=0 -> grant=0000, grant_valid=0, grant_idx=0, timeout=0 for 5 cycles.
- req=1010 held, done pulsed on each grant -> grant idx 3 (1000), bubble, then idx 1 (0010), bubble, then idx 3 again.
- req=1111 held, done each grant -> grant_idx sequence 3,2,1,0,3,2, with grant_valid low for one cycle between each.
- Drop release: grant idx 2 active, deassert req[2] with done=0 -> grant_valid=0 next cycle; req=0011 then yields idx 1.
- Async reset: grant idx 1 active, pull rst_n low mid-cycle -> outputs 0 before the next edge; after release with req=1111, first grant is idx 3.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, req=0100 held, done=0 -> grant_valid high 4 cycles, then low with timeout=1 for one cycle, then regrant idx 2.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter, MSB-first within a window rotating below the last grant; optional ARB_TIMEOUT_EN forced release.
// Latency: grant registered 1 cycle after req is sampled; one idle bubble after every release.
// Backpressure: owner holds the grant until done or its req drops; other requests wait.
module rr_grant_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    if (N_REQ < 2) begin : g_bad_n_req
        $error("rr_grant_arbiter: N_REQ must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_grant_arbiter: MAX_HOLD must be >= 1");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

    logic [N_REQ-1:0]   rot_req;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic               any_req;
    logic               rel_norm;
    logic               expire;
    logic               release_now;

    // Rotating {req,req} right by last_ptr puts requester last_ptr-1 at the MSB,
    // so an MSB-first pick walks last_ptr-1, last_ptr-2, ... with wrap modulo N_REQ.
    always_comb begin
        int pick;
        int win;
        rot_req = N_REQ'({req, req} >> last_ptr_q);
        pick    = 0;
        for (int j = 0; j < N_REQ; j++) begin
            if (rot_req[j]) pick = j;
        end
        win = pick + int'(last_ptr_q);
        if (win >= N_REQ) win = win - N_REQ;
        win_idx = IDX_W'(win);
    end

    assign win_oh      = N_REQ'(1) << win_idx;
    assign any_req     = |req;
    assign rel_norm    = (state_q == GRANT) && (done || !(|(req & grant_q)));
    assign release_now = rel_norm || expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)     state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_ptr_d  = last_ptr_q;
        case (state_q)
            IDLE: begin
                grant_d     = '0;
                grant_idx_d = '0;
                if (any_req) begin
                    grant_d     = win_oh;
                    grant_idx_d = win_idx;
                    last_ptr_d  = win_idx;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                end
            end
            default: begin
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_ptr_q  <= '0;
        end else begin
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = grant_idx_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    // hold_q counts completed grant cycles; the MAX_HOLD-th one forces release.
    assign expire = (state_q == GRANT) && (hold_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d    = hold_q;
        if (state_q == IDLE)  hold_d = '0;
        else if (!release_now) hold_d = hold_q + 1'b1;
        timeout_d = expire && !rel_norm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter (N_REQ=4, MAX_HOLD=4): vector table, directed corner sequences, randomized run vs. reference model.
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = '0;
    logic       done  = 1'b0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout;

    rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] r;
        logic       d;
        logic [3:0] eg;
        logic       ev;
        logic [1:0] ei;
    } vec_t;

    vec_t tbl [16];
    int   rr_seq [6] = '{3, 2, 1, 0, 3, 2};

    // Reference model state: who owns the resource and who won last.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_hold;
    bit m_to;

    task automatic check(input string nm, input logic [3:0] eg, input logic ev,
                         input logic [1:0] ei, input logic et);
        n_vec++;
        if (grant !== eg || grant_valid !== ev || grant_idx !== ei || timeout !== et) begin
            n_bad++;
            $display("FAIL %s t=%0t: got grant=%b vld=%b idx=%0d to=%b, want grant=%b vld=%b idx=%0d to=%b",
                     nm, $time, grant, grant_valid, grant_idx, timeout, eg, ev, ei, et);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_busy = 0; m_owner = 0; m_last = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        bit rel;
        bit exp_hit;
        bit found;
        if (!m_busy) begin
            m_to = 0;
            found = 0;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last - i + N) % N;
                if (!found && r[c[1:0]]) begin
                    found   = 1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_busy = 1;
                m_last = m_owner;
                m_hold = 0;
            end
        end else begin
            rel     = d || !r[m_owner[1:0]];
            m_hold  = m_hold + 1;
            exp_hit = 0;
`ifdef ARB_TIMEOUT_EN
            exp_hit = (m_hold >= MH);
`endif
            if (rel || exp_hit) begin
                m_busy = 0;
                m_to   = !rel;
            end else begin
                m_to = 0;
            end
        end
    endtask

    task automatic model_check(input string nm);
        logic [3:0] eg;
        logic [1:0] ei;
        eg = '0;
        ei = '0;
        if (m_busy) begin
            eg[m_owner[1:0]] = 1'b1;
            ei = m_owner[1:0];
        end
        check(nm, eg, m_busy, ei, m_to);
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[2]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[3]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[4]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[5]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{4'b0111, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[12] = '{4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[13] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[14] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

        // Reset state, checked while reset is held and for 5 idle cycles after.
        #1 rst_n = 1'b0;
        #2 check("in_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000, 1'b0);
            check("reset_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].d);
            check($sformatf("tbl[%0d]", i), tbl[i].eg, tbl[i].ev, tbl[i].ei, 1'b0);
        end

        // Full contention: rotation 3,2,1,0,3,2 with a bubble after each release.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic [3:0] oh;
            logic [1:0] ix;
            ix = rr_seq[k][1:0];
            oh = '0;
            oh[ix] = 1'b1;
            cyc(4'b1111, 1'b0);
            check($sformatf("rr_grant[%0d]", k), oh, 1'b1, ix, 1'b0);
            cyc(4'b1111, 1'b1);
            check($sformatf("rr_bubble[%0d]", k), 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        // Asynchronous reset mid-grant, then arbitration restarts from the top.
        do_reset();
        cyc(4'b0010, 1'b0);
        check("pre_arst", 4'b0010, 1'b1, 2'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("arst_clear", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1111, 1'b0);
        check("post_arst", 4'b1000, 1'b1, 2'd3, 1'b0);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < MH; i++) begin
            cyc(4'b0100, 1'b0);
            check($sformatf("hold[%0d]", i), 4'b0100, 1'b1, 2'd2, 1'b0);
        end
        cyc(4'b0100, 1'b0);
        check("timeout_pulse", 4'b0000, 1'b0, 2'd0, 1'b1);
        cyc(4'b0100, 1'b0);
        check("regrant", 4'b0100, 1'b1, 2'd2, 1'b0);
        // done on the expiry cycle is a normal release: no timeout pulse.
        for (int i = 1; i < MH; i++) cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b1);
        check("expiry_vs_done", 4'b0000, 1'b0, 2'd0, 1'b0);
`else
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0100, 1'b0);
            check($sformatf("hold_forever[%0d]", i), 4'b0100, 1'b1, 2'd2, 1'b0);
        end
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            logic       d;
            if (i < 1500) begin
                r = 4'($urandom_range(0, 15));
                d = ($urandom_range(0, 3) == 0);
            end else begin
                r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
                d = ($urandom_range(0, 7) == 0);
            end
            model_step(r, d);
            cyc(r, d);
            model_check("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
